mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that owns port B of the dual-port RAM and shares it among
// three requesters (glyph fetch, I/O, debug loader), returning read data one cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        rvalid_q, rvalid_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q, busy_d;

    logic [2:0]        elig_s;
    logic              win_valid_s;
    logic [1:0]        win_idx_s;
    logic [1:0]        cand_s;

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        case (v)
            2'd0:    inc_mod3 = 2'd1;
            2'd1:    inc_mod3 = 2'd2;
            default: inc_mod3 = 2'd0;
        endcase
    endfunction

    // Winner search: first eligible requester starting at the pointer; the
    // requester granted this cycle sits out so a held req cannot double-grant.
    always_comb begin
        elig_s      = req & ~gnt_q;
        win_valid_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!win_valid_s && elig_s[cand_s]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_valid_s = win_valid_s;
            end
            cand_s = inc_mod3(cand_s);
        end
    end

    // Next-state for grant, pointer and the registered RAM port B drive.
    always_comb begin
        gnt_d       = 3'b000;
        ptr_d       = ptr_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = {DATA_W{1'b0}};
        if (win_valid_s) begin
            gnt_d    = 3'b001 << win_idx_s;
            ptr_d    = inc_mod3(win_idx_s);
            ram_we_d = we[win_idx_s];
            case (win_idx_s)
                2'd0: begin
                    ram_addr_d  = addr0;
                    ram_wdata_d = wdata0;
                end
                2'd1: begin
                    ram_addr_d  = addr1;
                    ram_wdata_d = wdata1;
                end
                default: begin
                    ram_addr_d  = addr2;
                    ram_wdata_d = wdata2;
                end
            endcase
        end else begin
            gnt_d = 3'b000;
        end
        // RAM read latency is one cycle, so the read's rvalid trails its grant by one.
        rvalid_d = ram_we_q ? 3'b000 : gnt_q;
        busy_d   = (|gnt_d) | (|rvalid_d);
    end

    // State registers; reset clears ram_we at once so no write escapes after rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            ptr_q       <= 2'd0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_we_q    <= 1'b0;
            ram_wdata_q <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            ptr_q       <= ptr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign rdata     = ram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table driven through a behavioural
// synchronous-read RAM, plus hand sequences for fairness and reset during a transfer.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [9:0]  addr0, addr1, addr2;
    logic [15:0] wdata0, wdata1, wdata2;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_q;
    logic        busy;

    logic [15:0] mem [0:1023];

    int n_tests;
    int n_fail;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_q(ram_q), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural port-B RAM: synchronous read, contents preloaded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            mem[10'h005] <= 16'hBEEF;
            mem[10'h010] <= 16'hA010;
            mem[10'h020] <= 16'hC020;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [9:0]  a0;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [15:0] e_wd;
        logic        e_busy;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req = 3'b000; we = 3'b000;
        addr0 = 10'h000; addr1 = 10'h3FF; addr2 = 10'h020;
        wdata0 = 16'h0A0A; wdata1 = 16'h1234; wdata2 = 16'h0C0C;

        //          req     we      a0       gnt     rv      we    addr     wdata     busy  rdata
        vt[0]  = '{3'b101, 3'b000, 10'h010, 3'b001, 3'b000, 1'b0, 10'h010, 16'h0A0A, 1'b1, 16'h0000};
        vt[1]  = '{3'b100, 3'b000, 10'h010, 3'b100, 3'b001, 1'b0, 10'h020, 16'h0C0C, 1'b1, 16'hA010};
        vt[2]  = '{3'b000, 3'b000, 10'h010, 3'b000, 3'b100, 1'b0, 10'h020, 16'h0000, 1'b1, 16'hC020};
        vt[3]  = '{3'b000, 3'b000, 10'h010, 3'b000, 3'b000, 1'b0, 10'h020, 16'h0000, 1'b0, 16'h0000};
        vt[4]  = '{3'b001, 3'b000, 10'h005, 3'b001, 3'b000, 1'b0, 10'h005, 16'h0A0A, 1'b1, 16'h0000};
        vt[5]  = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b001, 1'b0, 10'h005, 16'h0000, 1'b1, 16'hBEEF};
        vt[6]  = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b000, 1'b0, 10'h005, 16'h0000, 1'b0, 16'h0000};
        vt[7]  = '{3'b010, 3'b010, 10'h005, 3'b010, 3'b000, 1'b1, 10'h3FF, 16'h1234, 1'b1, 16'h0000};
        vt[8]  = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b000, 1'b0, 10'h3FF, 16'h0000, 1'b0, 16'h0000};
        vt[9]  = '{3'b010, 3'b000, 10'h005, 3'b010, 3'b000, 1'b0, 10'h3FF, 16'h1234, 1'b1, 16'h0000};
        vt[10] = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b010, 1'b0, 10'h3FF, 16'h0000, 1'b1, 16'h1234};
        vt[11] = '{3'b001, 3'b000, 10'h005, 3'b001, 3'b000, 1'b0, 10'h005, 16'h0A0A, 1'b1, 16'h0000};
        vt[12] = '{3'b001, 3'b000, 10'h005, 3'b000, 3'b001, 1'b0, 10'h005, 16'h0000, 1'b1, 16'hBEEF};
        vt[13] = '{3'b001, 3'b000, 10'h005, 3'b001, 3'b000, 1'b0, 10'h005, 16'h0A0A, 1'b1, 16'h0000};
        vt[14] = '{3'b001, 3'b000, 10'h005, 3'b000, 3'b001, 1'b0, 10'h005, 16'h0000, 1'b1, 16'hBEEF};
        vt[15] = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b000, 1'b0, 10'h005, 16'h0000, 1'b0, 16'h0000};
        vt[16] = '{3'b011, 3'b000, 10'h005, 3'b010, 3'b000, 1'b0, 10'h3FF, 16'h1234, 1'b1, 16'h0000};
        vt[17] = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b010, 1'b0, 10'h3FF, 16'h0000, 1'b1, 16'h1234};
        vt[18] = '{3'b000, 3'b000, 10'h005, 3'b000, 3'b000, 1'b0, 10'h3FF, 16'h0000, 1'b0, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt", {29'd0, gnt}, 32'd0);
        check("reset_rvalid", {29'd0, rvalid}, 32'd0);
        check("reset_ram_we", {31'd0, ram_we}, 32'd0);
        check("reset_ram_addr", {22'd0, ram_addr}, 32'd0);
        check("reset_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req = vt[i].req; we = vt[i].we; addr0 = vt[i].a0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_gnt", i), {29'd0, gnt}, {29'd0, vt[i].e_gnt});
            check($sformatf("v%0d_rvalid", i), {29'd0, rvalid}, {29'd0, vt[i].e_rv});
            check($sformatf("v%0d_ram_we", i), {31'd0, ram_we}, {31'd0, vt[i].e_we});
            check($sformatf("v%0d_ram_addr", i), {22'd0, ram_addr}, {22'd0, vt[i].e_addr});
            check($sformatf("v%0d_ram_wdata", i), {16'd0, ram_wdata}, {16'd0, vt[i].e_wd});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
            if (vt[i].e_rv != 3'b000) begin
                check($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, vt[i].e_rd});
            end
        end

        // Fairness: all three held from reset rotate 0,1,2,0,1,2 with rvalid one behind.
        @(negedge clk);
        rst = 1'b1; req = 3'b000; we = 3'b000; addr0 = 10'h010;
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        begin
            logic [2:0] exp_g [6];
            logic [2:0] exp_r [6];
            exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
            exp_r = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("fair%0d_gnt", c), {29'd0, gnt}, {29'd0, exp_g[c]});
                check($sformatf("fair%0d_rvalid", c), {29'd0, rvalid}, {29'd0, exp_r[c]});
            end
        end

        // Reset pulsed during a read's grant cycle drops the pending rvalid.
        @(negedge clk);
        rst = 1'b1; req = 3'b000;
        @(negedge clk);
        rst = 1'b0; req = 3'b001; addr0 = 10'h005;
        @(posedge clk);
        #1;
        check("rstrd_gnt_before", {29'd0, gnt}, 32'd1);
        #2;
        rst = 1'b1;
        req = 3'b000;
        #1;
        check("rstrd_gnt_async", {29'd0, gnt}, 32'd0);
        check("rstrd_busy_async", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("rstrd_rvalid", {29'd0, rvalid}, 32'd0);
        check("rstrd_ram_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 3'b100;
        @(posedge clk);
        #1;
        check("rstrd_first_gnt", {29'd0, gnt}, 32'd4);
        check("rstrd_first_addr", {22'd0, ram_addr}, 32'h020);

        // Reset during a write grant pulls ram_we low without waiting for a clock.
        @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        req = 3'b010; we = 3'b010;
        @(posedge clk);
        #1;
        check("rstwr_ram_we_before", {31'd0, ram_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstwr_ram_we_async", {31'd0, ram_we}, 32'd0);
        check("rstwr_wdata_async", {16'd0, ram_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 3'b000; we = 3'b000;
        @(posedge clk);
        #1;
        check("rstwr_idle_gnt", {29'd0, gnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
